usrt_rx_shifter: RTL

//  Receive front end of the USRT. Samples the serial data line on the externally supplied

---
 rtl/usrt_pkg.sv | 19 +
 rtl/usrt_sync.sv | 38 +++
 rtl/usrt_rx_shifter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: FSM encoding, idle line level, parity helper.
package usrt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } usrt_state_e;

   // Serial line level while no frame is on the wire.
   localparam logic LINE_IDLE = 1'b1;

   // Parity bit a transmitter appends for the given data (narrow words zero-extended).
   function automatic logic usrt_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/usrt_sync.sv
// Synchronizes the serial clock and data into the system clock domain and
// produces a one-cycle strobe on the selected serial clock edge.
module usrt_sync
   import usrt_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SAMPLE_RISE = 1
) (
   input  logic i_Clk,
   input  logic i_Reset_n,
   input  logic i_Sclk,
   input  logic i_Rxd,
   output logic o_Edge,
   output logic o_Rxd
);

   logic [SYNC_STAGES-1:0] sclk_q;
   logic [SYNC_STAGES-1:0] rxd_q;
   logic                   sclk_last_q;

   // Synchronizer chains plus one history flop on Sclk; reset to idle level so no false edge.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         sclk_q      <= {SYNC_STAGES{LINE_IDLE}};
         rxd_q       <= {SYNC_STAGES{LINE_IDLE}};
         sclk_last_q <= LINE_IDLE;
      end else begin
         sclk_q      <= {sclk_q[SYNC_STAGES-2:0], i_Sclk};
         rxd_q       <= {rxd_q[SYNC_STAGES-2:0], i_Rxd};
         sclk_last_q <= sclk_q[SYNC_STAGES-1];
      end
   end

   assign o_Edge = (SAMPLE_RISE != 0) ? ( sclk_q[SYNC_STAGES-1] & ~sclk_last_q)
                                      : (~sclk_q[SYNC_STAGES-1] &  sclk_last_q);
   assign o_Rxd  = rxd_q[SYNC_STAGES-1];

endmodule

// File: rtl/usrt_rx_shifter.sv
// USRT receive front end: deframes start/data/parity/stop sampled on the
// serial clock and hands each byte downstream with a single-cycle push.
module usrt_rx_shifter
   import usrt_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SAMPLE_RISE = 1
) (
   input  logic                 i_Pclk,
   input  logic                 i_Reset_n,
   input  logic                 i_Sclk,
   input  logic                 i_Rxd,
   input  logic                 i_Enable,
   input  logic                 i_ParityEn,
   input  logic                 i_ParityOdd,
   input  logic                 i_Full,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Push,
   output logic                 o_ParityErr,
   output logic                 o_FrameErr,
   output logic                 o_Overrun,
   output logic                 o_Busy
);

   localparam int                 CNT_W    = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_BITS - 1);

   logic s_Edge;
   logic s_Rxd;

   usrt_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .SAMPLE_RISE (SAMPLE_RISE)
   ) u_sync (
      .i_Clk     (i_Pclk),
      .i_Reset_n (i_Reset_n),
      .i_Sclk    (i_Sclk),
      .i_Rxd     (i_Rxd),
      .o_Edge    (s_Edge),
      .o_Rxd     (s_Rxd)
   );

   usrt_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 rxpar_q, rxpar_d;
   logic                 pen_q, pen_d;
   logic                 podd_q, podd_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 push_q, push_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;

   // Frame FSM: advances on each serial sample strobe; pulses only ever last one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      rxpar_d = rxpar_q;
      pen_d   = pen_q;
      podd_d  = podd_q;
      data_d  = data_q;
      push_d  = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      if (!i_Enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (s_Edge) begin
         case (state_q)
            ST_IDLE: begin
               if (s_Rxd != LINE_IDLE) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
                  // Frame format is frozen at the start bit.
                  pen_d   = i_ParityEn;
                  podd_d  = i_ParityOdd;
               end
            end
            ST_DATA: begin
               shift_d = {s_Rxd, shift_q[DATA_BITS-1:1]};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = pen_q ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               rxpar_d = s_Rxd;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (s_Rxd) begin
                  push_d = 1'b1;
                  data_d = shift_q;
                  ovr_d  = i_Full;
                  perr_d = pen_q & (usrt_parity(8'(shift_q), podd_q) ^ rxpar_q);
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers; reset drops any frame in progress.
   always_ff @(posedge i_Pclk) begin
      if (!i_Reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         rxpar_q <= 1'b0;
         pen_q   <= 1'b0;
         podd_q  <= 1'b0;
         data_q  <= '0;
         push_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         rxpar_q <= rxpar_d;
         pen_q   <= pen_d;
         podd_q  <= podd_d;
         data_q  <= data_d;
         push_q  <= push_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign o_Data      = data_q;
   assign o_Push      = push_q;
   assign o_ParityErr = perr_q;
   assign o_FrameErr  = ferr_q;
   assign o_Overrun   = ovr_q;
   assign o_Busy      = (state_q != ST_IDLE);

endmodule
